// File: rtl/requant_relu8.sv
// rtl/requant_relu8.sv - requantize 12-bit neuron sums to 8-bit activations with optional ReLU, saturation and an output FIFO
module requant_relu8 #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_sum,
    input  logic [2:0]       shift,
    input  logic             relu_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] sat_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic signed [12:0] Q_MAX = 13'sd127;
    localparam logic signed [12:0] Q_MIN = -13'sd128;

    logic                    s1_valid;
    logic signed [12:0]      s1_r;
    logic [2:0]              s1_shift;
    logic                    s1_relu;

    logic                    s2_valid;
    logic signed [12:0]      s2_q;
    logic                    s2_relu;

    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           fifo_count;
    logic [8:0]              mem [DEPTH];

    logic                    in_fire;
    logic signed [12:0]      in_r;
    logic signed [12:0]      rnd;
    logic signed [12:0]      rsum;
    logic signed [12:0]      s2_next;
    logic [7:0]              sat_data;
    logic                    sat_flag;
    logic                    wr_en;
    logic                    rd_en;
    logic [CW:0]             occupancy;

    // Every accepted sample already owns a FIFO slot, so the pipeline never stalls.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(s1_valid) + (CW+1)'(s2_valid);
    assign in_ready  = occupancy < (CW+1)'(DEPTH);
    assign in_fire   = in_valid & in_ready;
    assign in_r      = (relu_en && in_sum[11]) ? 13'sd0 : $signed({in_sum[11], in_sum});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_fire;
        end
        if (in_fire) begin
            s1_r     <= in_r;
            s1_shift <= shift;
            s1_relu  <= relu_en;
        end
    end

    // Round half up: add half an output LSB before the arithmetic shift.
    always_comb begin
        rnd = '0;
        if (s1_shift != 3'd0) begin
            rnd[s1_shift - 3'd1] = 1'b1;
        end
    end

    assign rsum    = s1_r + rnd;
    assign s2_next = rsum >>> s1_shift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
        if (s1_valid) begin
            s2_q    <= s2_next;
            s2_relu <= s1_relu;
        end
    end

    always_comb begin
        sat_data = s2_q[7:0];
        sat_flag = 1'b0;
        if (s2_q > Q_MAX) begin
            sat_data = 8'h7f;
            sat_flag = 1'b1;
        end else if (s2_relu && (s2_q < 13'sd0)) begin
            sat_data = 8'h00;
            sat_flag = 1'b1;
        end else if (s2_q < Q_MIN) begin
            sat_data = 8'h80;
            sat_flag = 1'b1;
        end
    end

    assign wr_en     = s2_valid;
    assign out_valid = (fifo_count != '0);
    assign rd_en     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {sat_data, sat_flag};
        end
    end

    // A read only retires an entry that existed before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (wr_en && sat_flag && (sat_count != {CNT_W{1'b1}})) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

    assign out_data = out_valid ? mem[rd_ptr][8:1] : 8'h00;
    assign out_sat  = out_valid ? mem[rd_ptr][0]   : 1'b0;

endmodule

// File: tb/tb_requant_relu8.sv
// tb/tb_requant_relu8.sv - self-checking bench for requant_relu8
module tb_requant_relu8;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_sum;
    logic [2:0]  shift;
    logic        relu_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;
    logic [15:0] sat_count;

    logic        in_ready_b;
    logic        out_valid_b;
    logic [7:0]  out_data_b;
    logic        out_sat_b;
    logic [1:0]  sat_count_b;

    always #5 clk = ~clk;

    requant_relu8 #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .shift(shift), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .sat_count(sat_count)
    );

    // Small instance that saturates every sample, to exercise the counter ceiling.
    requant_relu8 #(.DEPTH(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(1'b1), .in_ready(in_ready_b),
        .in_sum(12'h7ff), .shift(3'd0), .relu_en(1'b0),
        .out_valid(out_valid_b), .out_ready(1'b1),
        .out_data(out_data_b), .out_sat(out_sat_b), .sat_count(sat_count_b)
    );

    typedef struct {
        logic [11:0] sum;
        logic [2:0]  sh;
        logic        relu;
        logic [7:0]  data;
        logic        sat;
    } vec_t;

    typedef struct {
        logic [8:0] ent;
        int         ready_at;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_n = 0;
    int   exp_sat = 0;
    exp_t q[$];
    logic got;
    logic pushed;
    logic [7:0] got_data;
    logic got_sat;
    vec_t tbl[13];

    always @(posedge clk) edge_n++;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference: floor((r + half) / 2^shift) with plain integer arithmetic, then clip.
    function automatic logic [8:0] model(input logic [11:0] sum, input logic [2:0] sh, input logic relu);
        int v, d, qv, lo;
        logic s;
        logic [7:0] dt;
        v = $signed(sum);
        if (relu && v < 0) v = 0;
        d = 1 << sh;
        if (sh > 0) v = v + d / 2;
        qv = (v >= 0) ? v / d : -((-v + d - 1) / d);
        lo = relu ? 0 : -128;
        s = 1'b0;
        if (qv > 127) begin qv = 127; s = 1'b1; end
        else if (qv < lo) begin qv = lo; s = 1'b1; end
        dt = qv[7:0];
        return {dt, s};
    endfunction

    task automatic cycle();
        logic exp_ov;
        logic [8:0] ent;
        @(negedge clk);
        got = 1'b0;
        pushed = 1'b0;
        check("in_ready", in_ready, q.size() < DEPTH);
        exp_ov = (q.size() > 0) && (q[0].ready_at <= edge_n);
        check("out_valid", out_valid, exp_ov);
        if (out_valid && exp_ov) check("head", {out_data, out_sat}, q[0].ent);
        if (!out_valid) check("idle_out", {out_data, out_sat}, 0);
        if (out_valid && out_ready && exp_ov) begin
            got = 1'b1;
            got_data = out_data;
            got_sat = out_sat;
            void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
            ent = model(in_sum, shift, relu_en);
            q.push_back('{ent, edge_n + 3});
            if (ent[0]) exp_sat++;
            pushed = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 40 && q.size() > 0; k++) cycle();
        check("drain_empty", q.size(), 0);
        cycle();
        check("sat_count", sat_count, exp_sat);
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        in_sum = v.sum; shift = v.sh; relu_en = v.relu;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        check({name, "_accepted"}, pushed, 1);
        in_valid = 1'b0;
        for (int k = 0; k < 8 && !got; k++) cycle();
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no output expected one", name);
        end else begin
            check({name, "_data"}, got_data, v.data);
            check({name, "_sat"}, got_sat, v.sat);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        q.delete();
        exp_sat = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sat_count", sat_count, 0);
        check("rst_out_data", {out_data, out_sat}, 0);
        check("rst_sat_count_b", sat_count_b, 0);
    endtask

    initial begin
        int acc;
        logic [7:0] seen [4];
        int nseen, npush, npop;

        tbl[0]  = '{12'h064, 3'd0, 1'b0, 8'h64, 1'b0};
        tbl[1]  = '{12'h7d0, 3'd2, 1'b0, 8'h7f, 1'b1};
        tbl[2]  = '{12'h800, 3'd0, 1'b0, 8'h80, 1'b1};
        tbl[3]  = '{12'hf38, 3'd0, 1'b1, 8'h00, 1'b0};
        tbl[4]  = '{12'hf38, 3'd1, 1'b0, 8'h9c, 1'b0};
        tbl[5]  = '{12'h005, 3'd1, 1'b0, 8'h03, 1'b0};
        tbl[6]  = '{12'h7ff, 3'd7, 1'b0, 8'h10, 1'b0};
        tbl[7]  = '{12'hfff, 3'd1, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{12'h003, 3'd2, 1'b0, 8'h01, 1'b0};
        tbl[9]  = '{12'h080, 3'd0, 1'b1, 8'h7f, 1'b1};
        tbl[10] = '{12'hf80, 3'd0, 1'b0, 8'h80, 1'b0};
        tbl[11] = '{12'hf7f, 3'd0, 1'b0, 8'h80, 1'b1};
        tbl[12] = '{12'hffb, 3'd1, 1'b0, 8'hfe, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sum = '0; shift = '0; relu_en = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 13; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));
        cycle();
        check("table_sat_count", sat_count, 4);
        check("sat_count_b_ceiling", sat_count_b, 3);

        // Backpressure: eight offers with the consumer stalled.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 1; i <= 8; i++) begin
            in_sum = 12'(i); shift = 3'd0; relu_en = 1'b0; in_valid = 1'b1;
            cycle();
            if (pushed) acc++;
        end
        check("full_accepted", acc, 4);
        in_valid = 1'b0;
        cycle();
        check("full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        nseen = 0;
        for (int k = 0; k < 20 && nseen < 4; k++) begin
            cycle();
            if (got) begin seen[nseen] = got_data; nseen++; end
        end
        check("full_drain_n", nseen, 4);
        for (int i = 0; i < 4; i++) check($sformatf("order%0d", i), seen[i], i + 1);

        // Full buffer, both sides streaming continuously.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 10 && q.size() < DEPTH; k++) begin
            in_sum = 12'(20 + k); cycle();
        end
        in_valid = 1'b0;
        repeat (3) cycle();
        check("stream_full", out_valid, 1);
        out_ready = 1'b1; in_valid = 1'b1;
        npush = 0; npop = 0;
        for (int k = 0; k < 16; k++) begin
            in_sum = 12'(40 + k);
            cycle();
            if (k >= 6) begin
                if (pushed) npush++;
                if (got) npop++;
                check("stream_in_ready", in_ready, 1);
            end
        end
        check("stream_push", npush, 10);
        check("stream_pop", npop, 10);
        drain();

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_sum = 12'($urandom);
            shift = 3'($urandom);
            relu_en = 1'($urandom);
            cycle();
        end
        drain();

        // Reset with two entries buffered and two in flight, transfers requested on that edge.
        out_ready = 1'b0; in_valid = 1'b1;
        in_sum = 12'h7ff; shift = 3'd0; relu_en = 1'b0;
        repeat (4) cycle();
        check("pre_rst_inflight", q.size(), 4);
        in_valid = 1'b1; out_ready = 1'b1;
        do_reset();
        out_ready = 1'b1;
        repeat (6) cycle();
        apply_vec(tbl[0], "post_rst");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
